// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants used by the fetch stage.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction+pc hold buffer that absorbs a response arriving while decode stalls.
module fetch_hold_buf
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fill,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic [PC_W-1:0]    fill_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] data,
  output logic [PC_W-1:0]    pc
);

  // clear (flush) wins over fill; fill and drain are mutually exclusive by stall
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= NOP;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
      pc    <= fill_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, single-outstanding imem requests, stall buffer, redirect squash.
// Optional perf counters (perf_bubbles, perf_flushes) when FETCH_CTRL_PERF_EN is defined.
//
// state | meaning
// IDLE  | just out of reset, request starts next cycle
// REQ   | imem_req asserted at pc while hold buffer is empty
// WAIT  | one request outstanding, response will be delivered
// DROP  | one request outstanding, response will be discarded
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int             PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_bubbles,
  output logic [31:0]        perf_flushes
`endif
);

  fetch_state_e       state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [PC_W-1:0]    req_pc, req_pc_nxt;
  logic               accept;
  logic               buf_valid;
  logic [INSTR_W-1:0] buf_data;
  logic [PC_W-1:0]    buf_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_pc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    imem_req   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = !buf_valid;
        if (imem_req && imem_gnt) begin
          req_pc_nxt = pc;
          pc_nxt     = pc + PC_W'(1);
          state_nxt  = redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
          accept    = !redirect;
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (redirect) pc_nxt = redirect_pc;
  end

  assign imem_addr = pc;

  fetch_hold_buf #(.PC_W(PC_W)) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .fill      (accept && stall),
    .drain     (!stall && buf_valid),
    .clear     (redirect),
    .fill_data (imem_rdata),
    .fill_pc   (req_pc),
    .valid     (buf_valid),
    .data      (buf_data),
    .pc        (buf_pc)
  );

  // redirect beats stall; buffered data beats a fresh response
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      instr_out   <= NOP;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else if (!stall) begin
      if (buf_valid) begin
        instr_out   <= buf_data;
        instr_valid <= 1'b1;
        instr_pc    <= buf_pc;
      end else if (accept) begin
        instr_out   <= imem_rdata;
        instr_valid <= 1'b1;
        instr_pc    <= req_pc;
      end else begin
        instr_out   <= NOP;
        instr_valid <= 1'b0;
        instr_pc    <= '0;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (!stall && !instr_valid && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
      if (redirect && perf_flushes != '1) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small instruction-memory model (data = addr + 100 unless overridden).
module tb_fetch_ctrl;
  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     instr_out;
  logic            instr_valid;
  logic [PC_W-1:0] instr_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]     perf_bubbles;
  logic [31:0]     perf_flushes;
`endif

  logic        gnt_en;
  int          lat;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_data;
  bit          ovr_en;
  logic [31:0] ovr_data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign imem_gnt = gnt_en & imem_req;

  fetch_ctrl #(.PC_W(PC_W), .RESET_PC(16'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: sample grant before the edge, drive memory response #1 after it
  task automatic tick();
    bit              granted;
    logic [PC_W-1:0] gaddr;
    granted = imem_req && gnt_en;
    gaddr   = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (granted) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_data = ovr_en ? ovr_data : 32'(gaddr) + 32'd100;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_data;
        pend        = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; gnt_en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; lat = 1; pend = 1'b0; pend_cnt = 0;
    pend_data = '0; ovr_en = 1'b0; ovr_data = '0;
    repeat (3) tick();
    check_val("rst_req", 32'(imem_req), 0);
    check_val("rst_valid", 32'(instr_valid), 0);
    check_val("rst_out", instr_out, 0);
    check_val("rst_pc", 32'(instr_pc), 0);

    // basic single-cycle memory stream
    rst = 1'b0;
    tick(); check_val("s1_req", 32'(imem_req), 1); check_val("s1_addr", 32'(imem_addr), 0);
    tick(); check_val("s2_valid", 32'(instr_valid), 0);
    tick(); check_val("s3_out", instr_out, 100); check_val("s3_pc", 32'(instr_pc), 0);
    check_val("s3_valid", 32'(instr_valid), 1); check_val("s3_addr", 32'(imem_addr), 1);
    tick(); check_val("s4_valid", 32'(instr_valid), 0); check_val("s4_out", instr_out, 0);
    tick(); check_val("s5_out", instr_out, 101); check_val("s5_pc", 32'(instr_pc), 1);
    check_val("s5_addr", 32'(imem_addr), 2);
    tick(); check_val("s6_valid", 32'(instr_valid), 0);
    tick(); check_val("s7_out", instr_out, 102); check_val("s7_pc", 32'(instr_pc), 2);

    // stall 4 cycles with a response landing in the buffer
    ovr_en = 1'b1; ovr_data = 32'hABCD0001; stall = 1'b1;
    tick(); check_val("st1_out", instr_out, 102); check_val("st1_valid", 32'(instr_valid), 1);
    ovr_en = 1'b0;
    tick(); check_val("st2_req", 32'(imem_req), 0); check_val("st2_out", instr_out, 102);
    tick(); check_val("st3_req", 32'(imem_req), 0);
    tick(); check_val("st4_req", 32'(imem_req), 0); check_val("st4_out", instr_out, 102);
    stall = 1'b0;
    tick(); check_val("st_rel_out", instr_out, 32'hABCD0001); check_val("st_rel_pc", 32'(instr_pc), 3);
    check_val("st_rel_valid", 32'(instr_valid), 1); check_val("st_rel_addr", 32'(imem_addr), 4);

    // redirect coinciding with rvalid in WAIT
    ovr_en = 1'b1; ovr_data = 32'h0000DEAD;
    tick(); check_val("rw0_valid", 32'(instr_valid), 0);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick(); redirect = 1'b0; ovr_en = 1'b0;
    check_val("rw1_valid", 32'(instr_valid), 0); check_val("rw1_out", instr_out, 0);
    check_val("rw1_req", 32'(imem_req), 1); check_val("rw1_addr", 32'(imem_addr), 32'h40);
    tick(); check_val("rw2_valid", 32'(instr_valid), 0);
    tick(); check_val("rw3_out", instr_out, 32'hA4); check_val("rw3_pc", 32'(instr_pc), 32'h40);

    // redirect in WAIT before a slow response: DROP path
    lat = 3; ovr_en = 1'b1;
    tick(); check_val("dr0_req", 32'(imem_req), 0);
    redirect = 1'b1; redirect_pc = 16'h0050;
    tick(); redirect = 1'b0;
    check_val("dr1_valid", 32'(instr_valid), 0); check_val("dr1_req", 32'(imem_req), 0);
    tick(); check_val("dr2_req", 32'(imem_req), 0);
    tick(); check_val("dr3_req", 32'(imem_req), 1); check_val("dr3_addr", 32'(imem_addr), 32'h50);
    check_val("dr3_valid", 32'(instr_valid), 0);
    lat = 1; ovr_en = 1'b0;
    tick(); check_val("dr4_valid", 32'(instr_valid), 0);
    tick(); check_val("dr5_out", instr_out, 32'hB4); check_val("dr5_pc", 32'(instr_pc), 32'h50);

    // redirect while stalled with a full buffer
    stall = 1'b1;
    tick(); check_val("sf1_out", instr_out, 32'hB4);
    tick(); check_val("sf2_req", 32'(imem_req), 0); check_val("sf2_valid", 32'(instr_valid), 1);
    redirect = 1'b1; redirect_pc = 16'h0060;
    tick(); redirect = 1'b0;
    check_val("sf3_valid", 32'(instr_valid), 0); check_val("sf3_out", instr_out, 0);
    check_val("sf3_req", 32'(imem_req), 1); check_val("sf3_addr", 32'(imem_addr), 32'h60);
    stall = 1'b0;
    tick(); check_val("sf4_valid", 32'(instr_valid), 0);
    tick(); check_val("sf5_out", instr_out, 32'hC4); check_val("sf5_pc", 32'(instr_pc), 32'h60);

    // grant withheld; redirect while request pending
    gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 16'h0007;
    tick(); redirect = 1'b0;
    check_val("ng1_addr", 32'(imem_addr), 7); check_val("ng1_req", 32'(imem_req), 1);
    tick(); check_val("ng2_addr", 32'(imem_addr), 7);
    tick(); check_val("ng3_addr", 32'(imem_addr), 7);
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick(); redirect = 1'b0; check_val("ng4_addr", 32'(imem_addr), 32'h10);
    tick(); check_val("ng5_addr", 32'(imem_addr), 32'h10); check_val("ng5_req", 32'(imem_req), 1);
    gnt_en = 1'b1;
    tick(); check_val("ng6_valid", 32'(instr_valid), 0);
    tick(); check_val("ng7_out", instr_out, 32'h74); check_val("ng7_pc", 32'(instr_pc), 32'h10);

    // redirect together with grant, then PC wrap
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick(); redirect = 1'b0;
    check_val("wr1_req", 32'(imem_req), 0); check_val("wr1_valid", 32'(instr_valid), 0);
    tick(); check_val("wr2_addr", 32'(imem_addr), 32'hFFFF); check_val("wr2_valid", 32'(instr_valid), 0);
    tick(); check_val("wr3_valid", 32'(instr_valid), 0);
    tick(); check_val("wr4_out", instr_out, 32'h10063); check_val("wr4_pc", 32'(instr_pc), 32'hFFFF);
    check_val("wr4_addr", 32'(imem_addr), 0); check_val("wr4_req", 32'(imem_req), 1);

    // reset mid-transaction: stale response must be ignored
    lat = 3; ovr_en = 1'b1; ovr_data = 32'h00000BAD;
    tick();
    rst = 1'b1;
    tick(); check_val("rm1_req", 32'(imem_req), 0); check_val("rm1_valid", 32'(instr_valid), 0);
    rst = 1'b0; lat = 1; ovr_en = 1'b0;
    tick(); check_val("rm2_req", 32'(imem_req), 1); check_val("rm2_addr", 32'(imem_addr), 0);
    tick(); check_val("rm3_valid", 32'(instr_valid), 0);
    tick(); check_val("rm4_out", instr_out, 100); check_val("rm4_pc", 32'(instr_pc), 0);
    check_val("rm4_valid", 32'(instr_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
